// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receiver: FSM encoding, counter width default
// and frame-length constants.
package uart_rx_pkg;

    localparam int unsigned CntWDefault  = 20;
    localparam int unsigned DataBits7    = 7;
    localparam int unsigned DataBits8    = 8;
    localparam int unsigned ParityBits   = 1;
    localparam int unsigned MaxFrameBits = DataBits8 + ParityBits;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StStart = 2'd1,
        StData  = 2'd2,
        StStop  = 2'd3
    } rx_state_e;

    // Bits between start and stop: 7 or 8 data bits plus an optional parity bit.
    function automatic logic [3:0] frame_len(input logic eight, input logic pen);
        return 4'(DataBits7) + {3'b000, eight} + {3'b000, pen};
    endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Loadable down-counter; expire pulses in the cycle the count reaches 1, so a load of N
// acts N cycles later. The count parks at 0 when not reloaded.
module uart_baud_cnt #(
    parameter int unsigned CNT_W = 20
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             expire
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire = (cnt_q == {{(CNT_W-1){1'b0}}, 1'b1});

endmodule

// File: rtl/uart_rx.sv
// UART receiver: synchronizer, start/data/stop FSM, shift register and status flags.
// Frame format is latched at start detection so mid-frame input changes are ignored.
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int unsigned CNT_W = CntWDefault
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [CNT_W-1:0] k,
    input  logic             eight,
    input  logic             pen,
    input  logic             ohel,
    input  logic             rx,
    input  logic             rd,
    output logic [7:0]       data,
    output logic             rxrdy,
    output logic             perr,
    output logic             ferr,
    output logic             ovf
);

    logic             rx_meta_q, rxs_q, rxs_prev_q;
    rx_state_e        state_q, state_d;
    logic             eight_q, eight_d, pen_q, pen_d, ohel_q, ohel_d;
    logic [CNT_W-1:0] k_q, k_d;
    logic [3:0]       bit_cnt_q, bit_cnt_d;
    logic [8:0]       shreg_q, shreg_d;
    logic [7:0]       data_q, data_d;
    logic             rxrdy_q, rxrdy_d, perr_q, perr_d, ferr_q, ferr_d, ovf_q, ovf_d;

    logic             cnt_load;
    logic [CNT_W-1:0] cnt_val;
    logic             cnt_expire;
    logic [3:0]       len;
    logic [8:0]       frame;

    uart_baud_cnt #(
        .CNT_W (CNT_W)
    ) u_baud_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (cnt_val),
        .expire   (cnt_expire)
    );

    // Bits arrive LSB first at the top of the shifter; realign so bit 0 is the first data bit.
    assign len   = frame_len(eight_q, pen_q);
    assign frame = shreg_q >> (4'(MaxFrameBits) - len);

    always_comb begin
        state_d   = state_q;
        eight_d   = eight_q;
        pen_d     = pen_q;
        ohel_d    = ohel_q;
        k_d       = k_q;
        bit_cnt_d = bit_cnt_q;
        shreg_d   = shreg_q;
        data_d    = data_q;
        rxrdy_d   = rxrdy_q;
        perr_d    = perr_q;
        ferr_d    = ferr_q;
        ovf_d     = ovf_q;
        cnt_load  = 1'b0;
        cnt_val   = k_q;

        if (rd) begin
            rxrdy_d = 1'b0;
            perr_d  = 1'b0;
            ferr_d  = 1'b0;
            ovf_d   = 1'b0;
        end

        unique case (state_q)
            StIdle: begin
                if (rxs_prev_q && !rxs_q) begin
                    eight_d   = eight;
                    pen_d     = pen;
                    ohel_d    = ohel;
                    k_d       = k;
                    bit_cnt_d = '0;
                    shreg_d   = '0;
                    // A bit time below 2 cycles cannot be sampled mid-bit; drop the frame.
                    if ((k >> 1) != '0) begin
                        state_d  = StStart;
                        cnt_load = 1'b1;
                        cnt_val  = k >> 1;
                    end
                end
            end
            StStart: begin
                if (cnt_expire) begin
                    if (!rxs_q) begin
                        state_d  = StData;
                        cnt_load = 1'b1;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            StData: begin
                if (cnt_expire) begin
                    shreg_d   = {rxs_q, shreg_q[8:1]};
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    cnt_load  = 1'b1;
                    if (bit_cnt_q == len - 4'd1) begin
                        state_d = StStop;
                    end
                end
            end
            StStop: begin
                if (cnt_expire) begin
                    state_d = StIdle;
                    data_d  = {eight_q & frame[7], frame[6:0]};
                    rxrdy_d = 1'b1;
                    ferr_d  = ~rxs_q;
                    perr_d  = pen_q & ((^frame) != ohel_q);
                    ovf_d   = rxrdy_q & ~rd;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rx_meta_q  <= 1'b1;
            rxs_q      <= 1'b1;
            rxs_prev_q <= 1'b1;
            state_q    <= StIdle;
            eight_q    <= 1'b0;
            pen_q      <= 1'b0;
            ohel_q     <= 1'b0;
            k_q        <= '0;
            bit_cnt_q  <= '0;
            shreg_q    <= '0;
            data_q     <= '0;
            rxrdy_q    <= 1'b0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            rx_meta_q  <= rx;
            rxs_q      <= rx_meta_q;
            rxs_prev_q <= rxs_q;
            state_q    <= state_d;
            eight_q    <= eight_d;
            pen_q      <= pen_d;
            ohel_q     <= ohel_d;
            k_q        <= k_d;
            bit_cnt_q  <= bit_cnt_d;
            shreg_q    <= shreg_d;
            data_q     <= data_d;
            rxrdy_q    <= rxrdy_d;
            perr_q     <= perr_d;
            ferr_q     <= ferr_d;
            ovf_q      <= ovf_d;
        end
    end

    assign data  = data_q;
    assign rxrdy = rxrdy_q;
    assign perr  = perr_q;
    assign ferr  = ferr_q;
    assign ovf   = ovf_q;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: directed frames plus randomized frames against a frame-level model.
module tb_uart_rx;

    logic        clk = 1'b0;
    logic        rst;
    logic [19:0] k;
    logic        eight, pen, ohel, rx, rd;
    logic [7:0]  data;
    logic        rxrdy, perr, ferr, ovf;

    int checks = 0;
    int errors = 0;

    logic [7:0] exp_data;
    logic       exp_rdy, exp_perr, exp_ferr, exp_ovf;

    always #5 clk = ~clk;

    uart_rx dut (
        .clk   (clk),
        .rst   (rst),
        .k     (k),
        .eight (eight),
        .pen   (pen),
        .ohel  (ohel),
        .rx    (rx),
        .rd    (rd),
        .data  (data),
        .rxrdy (rxrdy),
        .perr  (perr),
        .ferr  (ferr),
        .ovf   (ovf)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_outs(input string tag);
        check({tag, " data"},  32'(data),  32'(exp_data));
        check({tag, " rxrdy"}, 32'(rxrdy), 32'(exp_rdy));
        check({tag, " perr"},  32'(perr),  32'(exp_perr));
        check({tag, " ferr"},  32'(ferr),  32'(exp_ferr));
        check({tag, " ovf"},   32'(ovf),   32'(exp_ovf));
    endtask

    task automatic do_read(input string tag);
        @(negedge clk);
        rd = 1'b1;
        @(negedge clk);
        rd = 1'b0;
        exp_rdy  = 1'b0;
        exp_perr = 1'b0;
        exp_ferr = 1'b0;
        exp_ovf  = 1'b0;
        check_outs(tag);
    endtask

    // Drive one frame, kk cycles per bit. The receiver should complete the frame at edge
    // cmp_edge counted from the edge after the start bit is driven: 2 sync stages, one
    // detection edge, half a bit to mid-start, then one bit time per data/parity/stop bit.
    task automatic send_frame(input string tag, input int kk, input bit e8, input bit pe,
                              input bit od, input logic [7:0] byt, input bit par,
                              input bit stp, input bit rd_cmp, input int rst_at);
        logic       line[$];
        int         nb, total, cmp_edge, rise;
        bit         rdy0, aborted;
        logic [7:0] dexp;

        nb = 7 + int'(e8) + int'(pe);
        line.push_back(1'b0);
        for (int i = 0; i < 7 + int'(e8); i++) line.push_back(byt[i]);
        if (pe) line.push_back(par);
        line.push_back(stp);

        cmp_edge = 3 + kk / 2 + (nb + 1) * kk;
        total    = (nb + 2) * kk + kk / 2 + 6;
        rise     = -1;
        rdy0     = exp_rdy;
        aborted  = 1'b0;

        @(negedge clk);
        k     = 20'(kk);
        eight = e8;
        pen   = pe;
        ohel  = od;
        for (int c = 0; c < total; c++) begin
            if (rst_at >= 0 && c == rst_at + 1) begin
                exp_data = 8'h00;
                exp_rdy  = 1'b0;
                exp_perr = 1'b0;
                exp_ferr = 1'b0;
                exp_ovf  = 1'b0;
                check_outs({tag, " after_rst"});
                rst     = 1'b1;
                aborted = 1'b1;
            end
            if (rst_at >= 0 && c == rst_at) rst = 1'b0;
            // Scramble the format inputs once the frame is under way.
            if (c == 6) begin
                k     = 20'($urandom_range(0, 40));
                eight = 1'($urandom);
                pen   = 1'($urandom);
                ohel  = 1'($urandom);
            end
            rx = (aborted || c / kk >= line.size()) ? 1'b1 : line[c / kk];
            rd = rd_cmp && (c == cmp_edge - 1);
            @(negedge clk);
            if (rise < 0 && rxrdy === 1'b1) rise = c + 1;
        end
        rx = 1'b1;
        rd = 1'b0;

        if (rst_at < 0) begin
            if (!rdy0) check({tag, " latency"}, 32'(rise), 32'(cmp_edge));
            dexp     = e8 ? byt : {1'b0, byt[6:0]};
            exp_ovf  = rd_cmp ? 1'b0 : (exp_rdy | exp_ovf);
            exp_rdy  = 1'b1;
            exp_data = dexp;
            exp_ferr = ~stp;
            exp_perr = pe && (((^dexp) ^ par) != od);
        end
        check_outs(tag);
    endtask

    initial begin
        bit         re8, rpe, rod, rpar, rstp, rrd;
        int         rk;
        logic [7:0] rbyt;

        rst = 1'b0;
        rx = 1'b1;
        rd = 1'b0;
        k = 20'd10;
        eight = 1'b1;
        pen = 1'b0;
        ohel = 1'b0;
        exp_data = 8'h00;
        exp_rdy = 1'b0;
        exp_perr = 1'b0;
        exp_ferr = 1'b0;
        exp_ovf = 1'b0;
        repeat (4) @(negedge clk);
        check_outs("reset");
        rst = 1'b1;
        repeat (5) @(negedge clk);

        send_frame("8n1_a5", 10, 1, 0, 0, 8'hA5, 0, 1, 0, -1);
        do_read("read_keeps_data");

        send_frame("7e_41_ok", 16, 0, 1, 0, 8'h41, 0, 1, 0, -1);
        do_read("read_7e_ok");
        send_frame("7e_41_bad", 16, 0, 1, 0, 8'h41, 1, 1, 0, -1);
        do_read("read_7e_bad");

        // Glitch shorter than half a bit: false start, nothing received.
        @(negedge clk);
        k = 20'd10;
        rx = 1'b0;
        repeat (3) @(negedge clk);
        rx = 1'b1;
        repeat (40) @(negedge clk);
        check_outs("false_start");
        send_frame("after_false", 10, 1, 0, 0, 8'hC3, 0, 1, 0, -1);
        do_read("read_after_false");

        // Bit time below 2: frame dropped at detection.
        @(negedge clk);
        k = 20'd1;
        rx = 1'b0;
        repeat (20) @(negedge clk);
        rx = 1'b1;
        repeat (20) @(negedge clk);
        check_outs("k_lt_2");
        send_frame("after_k1", 10, 1, 1, 1, 8'h96, 1, 1, 0, -1);
        do_read("read_after_k1");

        send_frame("stop0_3c", 10, 1, 0, 0, 8'h3C, 0, 0, 0, -1);
        do_read("read_stop0");

        send_frame("ovf_11", 10, 1, 0, 0, 8'h11, 0, 1, 0, -1);
        send_frame("ovf_22", 10, 1, 0, 0, 8'h22, 0, 1, 0, -1);
        do_read("read_ovf");
        send_frame("rdcmp_11", 10, 1, 0, 0, 8'h11, 0, 1, 0, -1);
        send_frame("rdcmp_22", 10, 1, 0, 0, 8'h22, 0, 1, 1, -1);
        do_read("read_rdcmp");

        // Reset while the receiver is counting toward data bit 3.
        send_frame("rst_mid", 10, 1, 0, 0, 8'hE7, 0, 1, 0, 45);
        send_frame("after_rst_5a", 10, 1, 0, 0, 8'h5A, 0, 1, 0, -1);
        do_read("read_after_rst");

        for (int n = 0; n < 16; n++) begin
            rk   = int'($urandom_range(4, 24));
            re8  = 1'($urandom);
            rpe  = 1'($urandom);
            rod  = 1'($urandom);
            rbyt = 8'($urandom);
            rpar = rod ^ (^(re8 ? rbyt : {1'b0, rbyt[6:0]})) ^ ($urandom_range(0, 3) == 0);
            rstp = ($urandom_range(0, 4) != 0);
            rrd  = ($urandom_range(0, 3) == 0);
            send_frame($sformatf("rand%0d", n), rk, re8, rpe, rod, rbyt, rpar, rstp, rrd, -1);
            if ($urandom_range(0, 1) == 1) do_read($sformatf("rand_read%0d", n));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter CNT_W, default 20: width of the bit-time count input and of the internal baud counter.
REQ-002 clk  input  1  system clock; all state changes on its rising edge.
REQ-003 rst  input  1  reset, synchronous, active-low.
REQ-004 k  input  CNT_W  bit time, in clk cycles.
REQ-005 eight  input  1  1 = 8 data bits, 0 = 7 data bits.
REQ-006 pen  input  1  1 = parity bit present after the data bits.
REQ-007 ohel  input  1  parity sense: 1 = odd, 0 = even.
REQ-008 rx  input  1  asynchronous serial line, idle high.
REQ-009 rd  input  1  single-cycle read strobe: consumes the received byte and clears the status flags.
REQ-010 data  output  8  received byte, LSB first on the line; bit 7 = 0 in 7-bit mode.
REQ-011 rxrdy  output  1  a received byte is waiting to be read.
REQ-012 perr  output  1  parity error on the last frame.
REQ-013 ferr  output  1  framing error (stop bit sampled 0).
REQ-014 ovf  output  1  overrun: a frame completed while rxrdy was already 1.

Function
REQ-015 rx shall pass through a 2-flop synchronizer; all decisions use the synchronized value rxs.
REQ-016 The FSM shall have four states: IDLE, START, DATA, STOP.
REQ-017 IDLE: a 1-to-0 transition of rxs shall move the FSM to START, load the baud counter with k>>1, and latch eight, pen, ohel and k for the frame.
REQ-018 START: when the counter expires, rxs = 0 shall move the FSM to DATA with the counter reloaded to k; rxs = 1 is a false start and shall return the FSM to IDLE with no flag change.
REQ-019 DATA: the FSM shall sample one bit per counter expiry, then reload the counter to k.
REQ-020 DATA frame length: 7 + eight + pen bits, shifted in LSB first; then the FSM moves to STOP.
REQ-021 STOP: on counter expiry the FSM shall sample the stop bit, complete the frame, and return to IDLE in the same cycle.
REQ-022 Frame completion, same clock edge: data is loaded, rxrdy is set to 1, ferr = ~stop, perr = pen & (parity mismatch), and ovf is set to 1 if rxrdy was already 1.
REQ-023 Parity is checked over the 7 or 8 data bits plus the parity bit; the XOR of these bits shall equal ohel for a pass.
REQ-024 rd shall clear rxrdy, perr, ferr and ovf on the next edge.
REQ-025 If rd and frame completion occur in the same cycle, completion wins: rxrdy = 1, the new flags are loaded, and ovf = 0.
REQ-026 data shall hold its value until the next frame completes; rd does not clear data.
REQ-027 Changes to eight, pen, ohel or k during a frame shall have no effect until the next start detection.
REQ-028 A latched k < 2 shall abort the frame to IDLE at start detection, with no flag change.
REQ-029 Detection latency: start is sampled k>>1 cycles after the synchronized falling edge; each subsequent bit is sampled k cycles after the previous one.

Reset
REQ-030 While rst = 0 at a clock edge: FSM = IDLE, counter = 0, shift register = 0, data = 8'h00, and rxrdy, perr, ferr, ovf = 0; synchronizer flops = 1.
REQ-031 Reset asserted mid-frame shall discard the partial frame; after release, the receiver shall wait for a fresh 1-to-0 edge.

Structure
REQ-032 A shared package shall hold the FSM state encoding, the CNT_W default, and the frame-length constants (7, 8, parity +1).
REQ-033 One sub-module shall be used: uart_baud_cnt (loadable down-counter with an expiry pulse); the FSM, shift register and flags stay in uart_rx.

Verification
REQ-034 k=10, 8N1, byte 8'hA5 -> rxrdy=1 and data=8'hA5 after the stop sample; perr=0, ferr=0, ovf=0.
REQ-035 k=16, 7-bit, even parity, byte 7'h41 with correct parity bit 0 -> data=8'h41, perr=0; repeat with parity bit 1 -> perr=1.
REQ-036 rx low for 3 cycles then high, k=10 -> FSM returns to IDLE; rxrdy stays 0 and no flags change.
REQ-037 Stop bit driven 0, byte 8'h3C -> data=8'h3C, rxrdy=1, ferr=1.
REQ-038 Two frames (8'h11 then 8'h22) with no rd between -> data=8'h22, ovf=1; rd in the completion cycle of the second frame instead -> rxrdy=1, ovf=0.
REQ-039 rst=0 during DATA bit 3 -> all outputs 0 next cycle; a following full frame 8'h5A is received correctly.
